// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters.
// Results return with the requester ID over a valid/ready response channel.
module logic_op_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [3*NREQ-1:0]       req_op,
    input  logic [WIDTH*NREQ-1:0]   req_a,
    input  logic [WIDTH*NREQ-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [IDW-1:0]          rsp_id,
    output logic                    rsp_err,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_last;
    logic [IDW-1:0]     r_id;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic [NREQ-1:0]    w_ready;
    logic [WIDTH-1:0]   w_result;
    logic               w_err;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(r_last) + k) % NREQ;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (r_state == IDLE && w_found) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    assign req_ready = w_ready;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            3'd0:    w_result = r_a & r_b;
            3'd1:    w_result = r_a | r_b;
            3'd2:    w_result = ~r_a;
            3'd3:    w_result = ~(r_a & r_b);
            3'd4:    w_result = ~(r_a | r_b);
            3'd5:    w_result = r_a ^ r_b;
            3'd6:    w_result = ~(r_a ^ r_b);
            default: w_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= IDW'(NREQ - 1);
            r_id      <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_op    <= req_op[3*int'(w_winner) +: 3];
                        r_a     <= req_a[WIDTH*int'(w_winner) +: WIDTH];
                        r_b     <= req_b[WIDTH*int'(w_winner) +: WIDTH];
                        r_id    <= w_winner;
                        r_last  <= w_winner;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= w_result;
                    rsp_err   <= w_err;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter with hand-computed results.
module tb_logic_op_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [11:0]  req_op = '0;
    logic [31:0]  req_a = '0;
    logic [31:0]  req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [7:0]   rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic_op_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction from requester id with rsp_ready held high.
    task automatic applyStimulus(input int id, input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] expData,
                                 input logic expErr, input string tag);
        int n;
        @(negedge clk);
        req_valid = 4'(1 << id);
        req_op = '0;
        req_op[3*id +: 3] = op;
        req_a[8*id +: 8] = a;
        req_b[8*id +: 8] = b;
        rsp_ready = 1'b1;
        #1 checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'd1);
        checkOutput({tag, "_data"}, 32'(rsp_data), 32'(expData));
        checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
        checkOutput({tag, "_err"}, 32'(rsp_err), 32'(expErr));
        @(negedge clk);
        checkOutput({tag, "_idle"}, 32'({rsp_valid, busy}), 32'd0);
    endtask

    initial begin
        logic [7:0] sweepExp [7];
        int expOrder [6];
        int g;
        int r;
        int lastCyc;
        int n;

        sweepExp = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55};
        expOrder = '{0, 1, 2, 3, 0, 1};

        doReset();
        #1;
        checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);

        applyStimulus(0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, "t1_and");

        for (int op = 0; op < 7; op++) begin
            applyStimulus(2, 3'(op), 8'hA5, 8'h0F, sweepExp[op], 1'b0, $sformatf("t2_op%0d", op));
        end

        // Round-robin with all requesters held; pointer restarts at NREQ-1 after reset.
        doReset();
        @(negedge clk);
        req_op = '0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        g = 0;
        r = 0;
        lastCyc = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            #1;
            if (req_ready != 0) begin
                if (g < 6) checkOutput($sformatf("t3_grant%0d", g), 32'(req_ready), 32'(1 << expOrder[g]));
                if (g > 0) checkOutput($sformatf("t3_gap%0d", g), 32'(cyc - lastCyc), 32'd3);
                lastCyc = cyc;
                g++;
            end
            if (rsp_valid && r < 6) begin
                checkOutput($sformatf("t3_rspid%0d", r), 32'(rsp_id), 32'(expOrder[r]));
                r++;
            end
            @(negedge clk);
        end
        checkOutput("t3_grants", 32'(g), 32'd6);
        checkOutput("t3_rsps", 32'(r), 32'd6);
        req_valid = '0;
        repeat (4) @(negedge clk);

        applyStimulus(1, 3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1, "t4_illegal");

        // Backpressure with requester 3 waiting behind a stalled response.
        @(negedge clk);
        req_valid = 4'b0001;
        req_op = '0;
        req_op[2:0] = 3'd5;
        req_a[7:0] = 8'h12;
        req_b[7:0] = 8'h34;
        req_op[11:9] = 3'd1;
        req_a[31:24] = 8'h0C;
        req_b[31:24] = 8'h30;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b1000;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_rsp_seen", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t5_hold%0d", i),
                        {20'd0, rsp_valid, rsp_err, rsp_id, rsp_data},
                        {20'd0, 1'b1, 1'b0, 2'd0, 8'h26});
            checkOutput($sformatf("t5_noready%0d", i), 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t5_idle", 32'(busy), 32'd0);
        checkOutput("t5_grant3", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_r3_data", 32'(rsp_data), 32'h3C);
        checkOutput("t5_r3_id", 32'(rsp_id), 32'd3);
        repeat (2) @(negedge clk);

        // Reset while the captured operation is in EXEC.
        req_valid = 4'b0100;
        req_op[8:6] = 3'd0;
        @(negedge clk);
        req_valid = '0;
        checkOutput("t6_exec_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        req_valid = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("t6_first_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
